// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter that shares the 64-bit data memory between
//             the core and the loader/debug port. Each access runs as a
//             grant / memory drive / read wait / completion sequence, with
//             one transaction outstanding at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   // core port
   input  logic        C_REQ,
   input  logic        C_WR,
   input  logic [63:0] C_ADDR,
   input  logic [63:0] C_WDATA,
   output logic        C_GNT,
   output logic        C_DONE,
   output logic [63:0] C_RDATA,
   // loader / debug port
   input  logic        L_REQ,
   input  logic        L_WR,
   input  logic [63:0] L_ADDR,
   input  logic [63:0] L_WDATA,
   output logic        L_GNT,
   output logic        L_DONE,
   output logic [63:0] L_RDATA,
   // memory side
   output logic [63:0] MEM_ADDR,
   output logic [63:0] MEM_WDATA,
   output logic        MEM_WR,
   input  logic [63:0] MEM_RDATA,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic       c_core     = 1'b0;
   localparam logic       c_loader   = 1'b1;
   localparam logic [3:0] c_cnt_init = 4'(RD_LAT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_owner;
   logic        r_last;
   logic        r_op_wr;
   logic [3:0]  r_cnt;
   logic [63:0] r_mem_addr;
   logic [63:0] r_mem_wdata;
   logic [63:0] r_c_rdata;
   logic [63:0] r_l_rdata;
   logic        w_c_gnt;
   logic        w_l_gnt;
   logic        w_capture;

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next state, grants and read-capture strobe. On a tie the port that was
   // not served last wins; the counter holds the remaining wait cycles and
   // the read data is taken on the edge where it would reach zero.
   always_comb begin
      w_next_state = r_state;
      w_c_gnt      = 1'b0;
      w_l_gnt      = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (C_REQ && (!L_REQ || (r_last == c_loader))) w_c_gnt = 1'b1;
            else if (L_REQ)                                w_l_gnt = 1'b1;
            if (w_c_gnt || w_l_gnt) w_next_state = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_op_wr) begin
               w_next_state = S_DONE;
            end else if (RD_LAT == 1) begin
               w_capture    = 1'b1;
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd1) begin
               w_capture    = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Latch the accepted request; address and data hold until the next accept.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_op_wr     <= 1'b0;
         r_owner     <= c_core;
         r_last      <= c_loader;
      end else if (w_c_gnt || w_l_gnt) begin
         r_mem_addr  <= w_c_gnt ? C_ADDR  : L_ADDR;
         r_mem_wdata <= w_c_gnt ? C_WDATA : L_WDATA;
         r_op_wr     <= w_c_gnt ? C_WR    : L_WR;
         r_owner     <= w_c_gnt ? c_core  : c_loader;
         r_last      <= w_c_gnt ? c_core  : c_loader;
      end
   end

   // Read latency counter: loaded in ACCESS, counted down in WAIT.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                  r_cnt <= '0;
      else if (r_state == S_ACCESS) r_cnt <= c_cnt_init;
      else if (r_state == S_WAIT)   r_cnt <= r_cnt - 4'd1;
   end

   // Deliver read data only to the transaction owner.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_c_rdata <= '0;
         r_l_rdata <= '0;
      end else if (w_capture) begin
         if (r_owner == c_core) r_c_rdata <= MEM_RDATA;
         else                   r_l_rdata <= MEM_RDATA;
      end
   end

   assign C_GNT     = w_c_gnt;
   assign L_GNT     = w_l_gnt;
   assign C_DONE    = (r_state == S_DONE) && (r_owner == c_core);
   assign L_DONE    = (r_state == S_DONE) && (r_owner == c_loader);
   assign C_RDATA   = r_c_rdata;
   assign L_RDATA   = r_l_rdata;
   assign MEM_ADDR  = r_mem_addr;
   assign MEM_WDATA = r_mem_wdata;
   assign MEM_WR    = (r_state == S_ACCESS) && r_op_wr;
   assign BUSY      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed bench for dmem_arbiter (RD_LAT=3 main instance plus a
//             RD_LAT=1 instance) backed by a small data memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;

   // main instance signals
   logic        c_req, c_wr, l_req, l_wr;
   logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
   logic        c_gnt, c_done, l_gnt, l_done, mem_wr, busy;
   logic [63:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [63:0] mem [0:255];

   // single-cycle-latency instance signals
   logic        b_c_req, b_c_wr, b_l_req, b_l_wr;
   logic [63:0] b_c_addr, b_c_wdata, b_l_addr, b_l_wdata;
   logic        b_c_gnt, b_c_done, b_l_gnt, b_l_done, b_mem_wr, b_busy;
   logic [63:0] b_c_rdata, b_l_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.RD_LAT(3)) dut (
      .CLK(clk), .RESET(rst_n),
      .C_REQ(c_req), .C_WR(c_wr), .C_ADDR(c_addr), .C_WDATA(c_wdata),
      .C_GNT(c_gnt), .C_DONE(c_done), .C_RDATA(c_rdata),
      .L_REQ(l_req), .L_WR(l_wr), .L_ADDR(l_addr), .L_WDATA(l_wdata),
      .L_GNT(l_gnt), .L_DONE(l_done), .L_RDATA(l_rdata),
      .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WR(mem_wr),
      .MEM_RDATA(mem_rdata), .BUSY(busy)
   );

   dmem_arbiter #(.RD_LAT(1)) dut1 (
      .CLK(clk), .RESET(rst_n),
      .C_REQ(b_c_req), .C_WR(b_c_wr), .C_ADDR(b_c_addr), .C_WDATA(b_c_wdata),
      .C_GNT(b_c_gnt), .C_DONE(b_c_done), .C_RDATA(b_c_rdata),
      .L_REQ(b_l_req), .L_WR(b_l_wr), .L_ADDR(b_l_addr), .L_WDATA(b_l_wdata),
      .L_GNT(b_l_gnt), .L_DONE(b_l_done), .L_RDATA(b_l_rdata),
      .MEM_ADDR(b_mem_addr), .MEM_WDATA(b_mem_wdata), .MEM_WR(b_mem_wr),
      .MEM_RDATA(b_mem_rdata), .BUSY(b_busy)
   );

   // Data memory model: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_wr) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   // Second instance reads a fixed pattern derived from the address.
   assign b_mem_rdata = b_mem_addr ^ 64'hA5A5_A5A5_A5A5_A5A5;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
      l_req = 0; l_wr = 0; l_addr = '0; l_wdata = '0;
      b_c_req = 0; b_c_wr = 0; b_c_addr = '0; b_c_wdata = '0;
      b_l_req = 0; b_l_wr = 0; b_l_addr = '0; b_l_wdata = '0;
      repeat (2) @(negedge clk);

      // ---- reset state
      chk("rst_busy", 64'(busy), 0);
      chk("rst_mem_wr", 64'(mem_wr), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      chk("rst_dones", {62'd0, c_done, l_done}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- RD_LAT=1 read: done one cycle after ACCESS
      b_c_req = 1; b_c_wr = 0; b_c_addr = 64'h40;
      #1 chk("b_gnt", 64'(b_c_gnt), 1);
      @(negedge clk);
      chk("b_busy_access", 64'(b_busy), 1);
      chk("b_done_early", 64'(b_c_done), 0);
      b_c_req = 0;
      @(negedge clk);
      chk("b_done", 64'(b_c_done), 1);
      chk("b_rdata", b_c_rdata, 64'hA5A5_A5A5_A5A5_A5E5);
      chk("b_l_rdata", b_l_rdata, 0);
      @(negedge clk);
      chk("b_idle", 64'(b_busy), 0);

      // ---- core write 0x10 <= DEADBEEF
      c_req = 1; c_wr = 1; c_addr = 64'h10; c_wdata = 64'hDEAD_BEEF;
      #1;
      chk("w_c_gnt", 64'(c_gnt), 1);
      chk("w_l_gnt", 64'(l_gnt), 0);
      chk("w_wr_accept", 64'(mem_wr), 0);
      @(negedge clk);
      chk("w_wr_access", 64'(mem_wr), 1);
      chk("w_addr", mem_addr, 64'h10);
      chk("w_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("w_no_gnt_busy", 64'(c_gnt), 0);
      c_req = 0;
      @(negedge clk);
      chk("w_wr_done", 64'(mem_wr), 0);
      chk("w_dones", {62'd0, c_done, l_done}, 64'b10);
      chk("w_c_rdata", c_rdata, 0);
      chk("w_l_rdata", l_rdata, 0);
      @(negedge clk);
      chk("w_idle", {62'd0, busy, c_done}, 0);
      chk("w_addr_hold", mem_addr, 64'h10);

      // ---- core read 0x10 with RD_LAT=3
      c_req = 1; c_wr = 0; c_addr = 64'h10;
      #1 chk("r_gnt", 64'(c_gnt), 1);
      @(negedge clk);
      c_req = 0;
      chk("r_wr_access", 64'(mem_wr), 0);
      chk("r_busy1", 64'(busy), 1);
      @(negedge clk);
      chk("r_wait1", {62'd0, busy, c_done}, 64'b10);
      @(negedge clk);
      chk("r_wait2", {62'd0, busy, c_done}, 64'b10);
      chk("r_wr_wait", 64'(mem_wr), 0);
      @(negedge clk);
      chk("r_done", {62'd0, busy, c_done}, 64'b11);
      chk("r_rdata", c_rdata, 64'hDEAD_BEEF);
      chk("r_l_rdata", l_rdata, 0);
      @(negedge clk);
      chk("r_idle", {62'd0, busy, c_done}, 0);
      chk("r_rdata_hold", c_rdata, 64'hDEAD_BEEF);

      // ---- tie from reset: order C, L, C, L
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      c_req = 1; c_wr = 1; c_addr = 64'h50; c_wdata = 64'h1;
      l_req = 1; l_wr = 1; l_addr = 64'h58; l_wdata = 64'h2;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("tie_gnt%0d", k), {62'd0, c_gnt, l_gnt},
                (k % 2 == 0) ? 64'b10 : 64'b01);
         @(negedge clk);
         chk($sformatf("tie_addr%0d", k), mem_addr,
             (k % 2 == 0) ? 64'h50 : 64'h58);
         chk($sformatf("tie_nogrant%0d", k), {62'd0, c_gnt, l_gnt}, 0);
         if (k == 3) begin
            c_req = 0; l_req = 0;
         end
         @(negedge clk);
         chk($sformatf("tie_done%0d", k), {62'd0, c_done, l_done},
             (k % 2 == 0) ? 64'b10 : 64'b01);
         @(negedge clk);
      end
      chk("tie_mem_c", mem[8'h50], 64'h1);
      chk("tie_mem_l", mem[8'h58], 64'h2);

      // ---- loader write 0x20 <= 0x1234, then core read 0x20
      l_req = 1; l_wr = 1; l_addr = 64'h20; l_wdata = 64'h1234;
      #1 chk("lw_gnt", {62'd0, c_gnt, l_gnt}, 64'b01);
      @(negedge clk);
      l_req = 0;
      @(negedge clk);
      chk("lw_done", {62'd0, c_done, l_done}, 64'b01);
      chk("lw_l_rdata", l_rdata, 0);
      @(negedge clk);
      c_req = 1; c_wr = 0; c_addr = 64'h20;
      #1 chk("cr_gnt", 64'(c_gnt), 1);
      @(negedge clk);
      c_req = 0;
      repeat (3) @(negedge clk);
      chk("cr_done", {62'd0, c_done, l_done}, 64'b10);
      chk("cr_rdata", c_rdata, 64'h1234);
      chk("cr_l_rdata", l_rdata, 0);
      @(negedge clk);

      // ---- reset during WAIT of a loader read
      l_req = 1; l_wr = 0; l_addr = 64'h20;
      #1 chk("rw_gnt", 64'(l_gnt), 1);
      @(negedge clk);
      l_req = 0;
      @(negedge clk);
      chk("rw_busy_wait", 64'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("rw_busy_rst", 64'(busy), 0);
      chk("rw_wr_rst", 64'(mem_wr), 0);
      chk("rw_l_rdata", l_rdata, 0);
      chk("rw_c_rdata", c_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rw_no_done", {62'd0, c_done, l_done}, 0);
      chk("rw_idle", 64'(busy), 0);
      c_req = 1; c_wr = 1; c_addr = 64'h60; c_wdata = 64'h7;
      #1 chk("rw_next_gnt", 64'(c_gnt), 1);
      @(negedge clk);
      c_req = 0;
      chk("rw_next_wr", {63'd0, mem_wr}, 1);
      chk("rw_next_addr", mem_addr, 64'h60);
      @(negedge clk);
      chk("rw_next_done", 64'(c_done), 1);
      @(negedge clk);

      // ---- core request raised and withdrawn while loader is busy
      l_req = 1; l_wr = 1; l_addr = 64'h68; l_wdata = 64'h99;
      #1 chk("cx_l_gnt", 64'(l_gnt), 1);
      @(negedge clk);
      l_req = 0;
      c_req = 1; c_wr = 1; c_addr = 64'h70; c_wdata = 64'h55;
      #1 chk("cx_c_gnt_access", 64'(c_gnt), 0);
      chk("cx_addr", mem_addr, 64'h68);
      @(negedge clk);
      chk("cx_c_gnt_done", 64'(c_gnt), 0);
      chk("cx_l_done", {62'd0, c_done, l_done}, 64'b01);
      c_req = 0;
      @(negedge clk);
      chk("cx_idle", {62'd0, busy, c_gnt}, 0);
      chk("cx_mem_core", mem[8'h70], 0);
      chk("cx_mem_loader", mem[8'h68], 64'h99);
      chk("cx_addr_hold", mem_addr, 64'h68);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
